// File: rtl/logic_unit_pkg.sv
// Shared opcode definitions for the pipelined logic unit.
// lu_op_e enumerates the eight 3-bit bitwise opcodes used by
// logic_unit_pipe and lu_core.
package logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,  // a & b
    OP_OR   = 3'b001,  // a | b
    OP_NOTA = 3'b010,  // ~a
    OP_NAND = 3'b011,  // ~(a & b)
    OP_NOR  = 3'b100,  // ~(a | b)
    OP_XOR  = 3'b101,  // a ^ b
    OP_XNOR = 3'b110,  // ~(a ^ b)
    OP_PASS = 3'b111   // a
  } lu_op_e;

endpackage

// File: rtl/lu_core.sv
// Combinational WIDTH-bit bitwise logic function.
// Ports:
//   op_i  opcode (lu_op_e)
//   a_i   operand A
//   b_i   operand B
//   f_o   result
module lu_core
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  lu_op_e           op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] f_o
);

  always_comb begin
    f_o = '0;
    case (op_i)
      OP_AND:  f_o = a_i & b_i;
      OP_OR:   f_o = a_i | b_i;
      OP_NOTA: f_o = ~a_i;
      OP_NAND: f_o = ~(a_i & b_i);
      OP_NOR:  f_o = ~(a_i | b_i);
      OP_XOR:  f_o = a_i ^ b_i;
      OP_XNOR: f_o = ~(a_i ^ b_i);
      OP_PASS: f_o = a_i;
      default: f_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipelined bitwise logic unit.
// S1 registers op/a/b, lu_core computes f, S2 registers f (and flags).
// Optional macro LU_FLAGS_EN adds registered zero/parity outputs.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand beat present      in_ready   beat accepted this cycle
//   op, a, b   opcode and operands
//   out_valid  result beat present       out_ready  consumer accepts result
//   f          result
//   zero       f == 0       (LU_FLAGS_EN only)
//   parity     XOR of f     (LU_FLAGS_EN only)
//   op_count   count of consumed results, wraps
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
`ifdef LU_FLAGS_EN
  output logic             zero,
  output logic             parity,
`endif
  output logic [CNT_W-1:0] op_count
);

  lu_op_e           s1_op_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic             s1_valid_q, s2_valid_q;
  logic [WIDTH-1:0] f_q, f_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s2_load, in_fire, out_fire;

  // S2 can take a new beat when empty or when its beat leaves this cycle;
  // S1 drains into S2 under the same condition, so in_ready needs no bubble.
  assign s2_load  = ~s2_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_load;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = s2_valid_q & out_ready;
  assign cnt_d    = out_fire ? cnt_q + CNT_W'(1) : cnt_q;

  lu_core #(.WIDTH(WIDTH)) u_core (
    .op_i (s1_op_q),
    .a_i  (s1_a_q),
    .b_i  (s1_b_q),
    .f_o  (f_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_AND;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      f_q        <= '0;
      cnt_q      <= '0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (in_fire) begin
        s1_op_q <= lu_op_e'(op);
        s1_a_q  <= a;
        s1_b_q  <= b;
      end
      if (s2_load) s2_valid_q <= s1_valid_q;
      if (s2_load && s1_valid_q) f_q <= f_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign f         = f_q;
  assign op_count  = cnt_q;

`ifdef LU_FLAGS_EN
  logic zero_q, parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
    end else if (s2_load && s1_valid_q) begin
      zero_q   <= ~|f_d;
      parity_q <= ^f_d;
    end
  end

  assign zero   = zero_q;
  assign parity = parity_q;
`endif

endmodule
